// File: rtl/writeback_queue.sv
// writeback_queue
//   In-order FIFO of register write-back requests that feeds a register-file
//   decoder. A request {addr, data} is accepted at the tail on a valid/ready
//   handshake. The head entry is presented to the decoder and is retired on
//   any cycle where the queue is non-empty and neither stall nor flush is set.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high; empties the queue
//   wr_valid   : producer offers a request
//   wr_addr    : destination register index of the offer      [n-1:0]
//   wr_data    : data of the offer                            [w-1:0]
//   wr_ready   : queue accepts a request this cycle
//   stall      : downstream holds; nothing retires
//   flush      : discard every queued request
//   dec_in     : head register index to the decoder select    [n-1:0]
//   dec_enable : head entry retires this cycle (decoder enable)
//   wb_data    : head entry data                              [w-1:0]
//   count      : occupied entries                             [clog2(depth):0]
//   busy       : queue non-empty
module writeback_queue #(
  parameter int n     = 3,
  parameter int w     = 16,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [n-1:0]             wr_addr,
  input  logic [w-1:0]             wr_data,
  output logic                     wr_ready,
  input  logic                     stall,
  input  logic                     flush,
  output logic [n-1:0]             dec_in,
  output logic                     dec_enable,
  output logic [w-1:0]             wb_data,
  output logic [$clog2(depth):0]   count,
  output logic                     busy
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] full_count = cw'(depth);

  logic [n-1:0]  addr_mem [depth];
  logic [w-1:0]  data_mem [depth];
  logic [aw-1:0] head;
  logic [aw-1:0] tail;
  logic          push;
  logic          pop;
  logic          empty;

  assign empty = (count == '0);

  // Ready and retire depend only on registered state and control inputs, so
  // a freshly pushed entry cannot bypass to the decoder in the same cycle,
  // and a full queue stays not-ready even while it pops.
  assign wr_ready   = !reset && !flush && (count < full_count);
  assign pop        = !reset && !flush && !stall && !empty;
  assign push       = wr_valid && wr_ready;
  assign dec_enable = pop;
  assign busy       = !empty;

  // Head presentation is forced to zero when empty or in reset so the
  // decoder never sees stale contents of an unoccupied slot.
  assign dec_in  = (reset || empty) ? '0 : addr_mem[head];
  assign wb_data = (reset || empty) ? '0 : data_mem[head];

  // NOTE: the storage array has no reset; occupancy is tracked by the
  // pointers and count, so clearing the contents would add logic for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= wr_addr;
      data_mem[tail] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + aw'(1);
      if (pop)  head <= head + aw'(1);
      // Power-of-two depth lets the pointers wrap naturally; count is kept
      // separately so full and empty are distinguishable.
      case ({push, pop})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue
//   Drives writeback_queue with directed scenarios and a randomized phase,
//   comparing every output each cycle against a queue-based reference model.
module tb_writeback_queue;

  localparam int n     = 3;
  localparam int w     = 16;
  localparam int depth = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   wr_valid;
  logic [n-1:0]           wr_addr;
  logic [w-1:0]           wr_data;
  logic                   wr_ready;
  logic                   stall;
  logic                   flush;
  logic [n-1:0]           dec_in;
  logic                   dec_enable;
  logic [w-1:0]           wb_data;
  logic [$clog2(depth):0] count;
  logic                   busy;

  typedef struct packed {
    logic [n-1:0] addr;
    logic [w-1:0] data;
  } req_t;

  req_t         model_q[$];
  logic [n-1:0] ret_addr[$];
  logic [w-1:0] ret_data[$];
  logic         last_accepted;

  int checks = 0;
  int errors = 0;

  writeback_queue #(.n(n), .w(w), .depth(depth)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .stall      (stall),
    .flush      (flush),
    .dec_in     (dec_in),
    .dec_enable (dec_enable),
    .wb_data    (wb_data),
    .count      (count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare outputs against the model, then
  // let the edge happen and advance the model by the queue rules.
  task automatic step(input logic v, input logic [n-1:0] a, input logic [w-1:0] d,
                      input logic s, input logic f, input logic r);
    logic         exp_ready;
    logic         exp_en;
    logic [n-1:0] exp_addr;
    logic [w-1:0] exp_data;
    wr_valid = v; wr_addr = a; wr_data = d; stall = s; flush = f; reset = r;
    #3;
    exp_ready = !r && !f && (model_q.size() < depth);
    exp_en    = !r && !f && !s && (model_q.size() > 0);
    exp_addr  = (r || model_q.size() == 0) ? '0 : model_q[0].addr;
    exp_data  = (r || model_q.size() == 0) ? '0 : model_q[0].data;
    check("wr_ready",   32'(wr_ready),   32'(exp_ready));
    check("dec_enable", 32'(dec_enable), 32'(exp_en));
    check("dec_in",     32'(dec_in),     32'(exp_addr));
    check("wb_data",    32'(wb_data),    32'(exp_data));
    check("busy",       32'(busy),       32'(model_q.size() > 0));
    if (!r) check("count", 32'(count), 32'(model_q.size()));
    if (dec_enable) begin
      ret_addr.push_back(dec_in);
      ret_data.push_back(wb_data);
    end
    last_accepted = v && exp_ready;
    @(posedge clk);
    if (r || f) begin
      model_q.delete();
    end else begin
      if (exp_en) void'(model_q.pop_front());
      if (v && exp_ready) model_q.push_back('{addr: a, data: d});
    end
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [n-1:0] exp_seq[$];
    logic         hold_v;
    logic [n-1:0] hold_a;
    logic [w-1:0] hold_d;

    wr_valid = 0; wr_addr = '0; wr_data = '0; stall = 0; flush = 0; reset = 1;
    repeat (2) @(posedge clk);
    #1;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Single write, no stall
    ret_addr.delete(); ret_data.delete();
    step(1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("single_cnt", 32'(ret_addr.size()), 32'd1);
    if (ret_addr.size() == 1) begin
      check("single_addr", 32'(ret_addr[0]), 32'd5);
      check("single_data", 32'(ret_data[0]), 32'hBEEF);
    end

    // Fill under stall, fifth offer refused until first pop frees a slot
    ret_addr.delete(); ret_data.delete();
    for (int i = 1; i <= 4; i++) step(1'b1, n'(i), w'(16'h100 + i), 1'b1, 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd4);
    step(1'b1, 3'd7, 16'h0777, 1'b1, 1'b0, 1'b0);
    check("full_refuse", 32'(last_accepted), 32'd0);
    do step(1'b1, 3'd7, 16'h0777, 1'b0, 1'b0, 1'b0); while (!last_accepted && ret_addr.size() < 8);
    check("seventh_after_pop", 32'(ret_addr.size()), 32'd2);
    idle(6);
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    check("fill_ret_cnt", 32'(ret_addr.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < ret_addr.size(); i++)
      check("fill_order", 32'(ret_addr[i]), 32'(exp_seq[i]));

    // Steady streaming with pointer wrap
    ret_addr.delete(); ret_data.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, n'(i % 8), w'($urandom), 1'b0, 1'b0, 1'b0);
      check("stream_count", 32'(count), 32'd1);
    end
    idle(2);
    check("stream_ret_cnt", 32'(ret_addr.size()), 32'd10);
    for (int i = 0; i < 10 && i < ret_addr.size(); i++)
      check("stream_order", 32'(ret_addr[i]), 32'(i % 8));

    // Flush mid-stream with a simultaneous offer
    for (int i = 0; i < 3; i++) step(1'b1, n'(i + 2), w'(i), 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd6, 16'h6666, 1'b0, 1'b1, 1'b0);
    check("flush_refuse", 32'(last_accepted), 32'd0);
    check("flush_count", 32'(count), 32'd0);
    idle(1);

    // Reset mid-operation
    for (int i = 0; i < 2; i++) step(1'b1, n'(i + 1), w'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("rst_count", 32'(count), 32'd0);
    idle(1);

    // Duplicate address kept as two entries
    ret_addr.delete(); ret_data.delete();
    step(1'b1, 3'd3, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd3, 16'hBBBB, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("dup_cnt", 32'(ret_data.size()), 32'd2);
    if (ret_data.size() == 2) begin
      check("dup_first",  32'(ret_data[0]), 32'hAAAA);
      check("dup_second", 32'(ret_data[1]), 32'hBBBB);
    end

    // Randomized phase; a refused offer is held until it is accepted
    hold_v = 0; hold_a = '0; hold_d = '0;
    for (int i = 0; i < 400; i++) begin
      logic s, f, r;
      if (!hold_v && $urandom_range(99) < 65) begin
        hold_v = 1; hold_a = n'($urandom); hold_d = w'($urandom);
      end
      s = ($urandom_range(99) < 35);
      f = ($urandom_range(99) < 3);
      r = ($urandom_range(99) < 2);
      step(hold_v, hold_a, hold_d, s, f, r);
      if (last_accepted) hold_v = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter n, default 3: register-address width; matches the width of the downstream decoder select input.
REQ-002 Parameter w, default 16: write-back data width.
REQ-003 Parameter depth, default 4: queue entries; power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_valid  input  1  producer offers a write-back request this cycle.
REQ-007 wr_addr  input  n  destination register index of the offered request.
REQ-008 wr_data  input  w  data of the offered request.
REQ-009 wr_ready  output  1  queue accepts a request this cycle.
REQ-010 stall  input  1  downstream holds; no request is retired this cycle.
REQ-011 flush  input  1  discard all queued requests.
REQ-012 dec_in  output  n  head-entry register index, driven to the decoder select.
REQ-013 dec_enable  output  1  head entry is being retired this cycle; drives the decoder enable.
REQ-014 wb_data  output  w  head-entry data, valid whenever dec_enable is 1.
REQ-015 count  output  clog2(depth)+1  number of occupied entries.
REQ-016 busy  output  1  count nonzero.

Function
REQ-017 Accept: a push occurs when wr_valid and wr_ready are both 1; {wr_addr, wr_data} is written at the tail.
REQ-018 wr_ready = (count < depth) and not flush; combinational from registered state; never depends on wr_valid.
REQ-019 Offer without ready: the request is not stored, no state change, and no error; the producer holds its request.
REQ-020 Retire: a pop occurs when count > 0, stall = 0, and flush = 0; dec_enable equals the pop condition, combinationally.
REQ-021 dec_in and wb_data always present the head entry; when count = 0 they are all-zero.
REQ-022 Latency: a request pushed into an empty queue appears with dec_enable = 1 in the next cycle at the earliest, with zero-cycle bypass forbidden.
REQ-023 Ordering: requests retire strictly in acceptance order; duplicate addresses are kept as separate entries and are not merged.
REQ-024 Simultaneous push and pop: both take effect; count is unchanged.
REQ-025 Full with pop in the same cycle: wr_ready stays 0, because no same-cycle slot reuse is allowed.
REQ-026 Pointers: head and tail are log2(depth)-bit counters that wrap from depth-1 to 0; count tracks occupancy independently, so full and empty are distinguishable.
REQ-027 Flush: dec_enable is 0 and no push occurs in the flush cycle; on the next edge count, head and tail become 0.
REQ-028 Flush has priority over stall, push and pop; stall has priority over pop only.
REQ-029 count never exceeds depth and never underflows; pop with count = 0 is impossible by construction.

Reset
REQ-030 With reset = 1 at an edge, head, tail and count become 0; stored entry contents are don't-care.
REQ-031 While reset is asserted, wr_ready = 0 and dec_enable = 0; dec_in and wb_data = 0.
REQ-032 Reset asserted mid-operation discards all queued requests, identically to flush; reset has priority over flush.
REQ-033 In the first cycle after reset deasserts: wr_ready = 1, busy = 0, count = 0.

Verification
REQ-034 Single write, no stall: push (addr 5, data 16'hBEEF) at cycle 0 -> cycle 1: dec_enable = 1, dec_in = 5, wb_data = BEEF; cycle 2: count = 0, busy = 0.
REQ-035 Fill under stall: stall = 1, push addrs 1,2,3,4 -> count = 4, wr_ready = 0; a 5th offer (addr 7) is not accepted; release stall -> dec_in sequence 1,2,3,4 on consecutive cycles; addr 7 is accepted after the first pop.
REQ-036 Steady streaming: push every cycle with stall = 0 for 10 cycles (addrs 0..7,0,1) -> count stays 1 after the first push; retire order matches; pointers wrap without loss.
REQ-037 Flush mid-stream: 3 entries queued, flush = 1 for 1 cycle -> dec_enable = 0 that cycle; next cycle count = 0; a simultaneous wr_valid is not accepted.
REQ-038 Reset mid-operation: 2 entries queued, reset = 1 for 1 cycle -> dec_enable = 0 during reset; afterwards count = 0, wr_ready = 1, dec_in = 0.
REQ-039 Duplicate address: push addr 3 data A then addr 3 data B -> two retirements with dec_in = 3, data A then data B.
